mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between those units and the memory/bus slave. A three-state FSM owns the port for a complete request/response transaction. Grant selection is either round-robin or fixed LSU-priority. A sticky watchdog flag reports a slave that never responds.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/bus slave port between the instruction
// fetch unit (IFU) and the load/store unit (LSU). A three-state FSM owns the
// port for a whole request/response transaction. Grants are round-robin or
// fixed LSU priority, and a sticky watchdog flags a slave that never answers.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 1,
    parameter int HANG_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,

    // IFU request / response
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                ifu_wen,
    input  logic [DATA_W-1:0]   ifu_wdata,
    input  logic [DATA_W/8-1:0] ifu_wmask,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    // LSU request / response
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    // Slave request / response
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    // Status
    output logic [1:0]          grant,
    output logic                hang
);

    // Counter wide enough to hold HANG_CYCLES itself; it saturates there.
    localparam int CNT_W = $clog2(HANG_CYCLES + 1);
    localparam logic [CNT_W-1:0] HANG_MAX = CNT_W'(HANG_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       grant_next;
    logic             last_lsu;       // 1: LSU was served last, 0: IFU
    logic             last_lsu_next;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_next;
    logic             hang_next;
    logic             req_valid_sel;
    logic             resp_ready_sel;

    // State, owner, fairness history and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last_lsu <= 1'b0;
            wd_cnt   <= '0;
            hang     <= 1'b0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            last_lsu <= last_lsu_next;
            wd_cnt   <= wd_cnt_next;
            hang     <= hang_next;
        end
    end

    // Watchdog: counts cycles spent owning the slave, saturating at the limit;
    // the flag is sticky and never aborts the transaction.
    always_comb begin
        wd_cnt_next = wd_cnt;
        if (state == IDLE) begin
            wd_cnt_next = '0;
        end else if (wd_cnt != HANG_MAX) begin
            wd_cnt_next = wd_cnt + CNT_W'(1);
        end
        hang_next = hang | (wd_cnt_next == HANG_MAX);
    end

    // Next-state, grant selection and the request/response crossbar
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        last_lsu_next  = last_lsu;

        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        s_req_valid    = 1'b0;
        s_addr         = '0;
        s_wen          = 1'b0;
        s_wdata        = '0;
        s_wmask        = '0;
        s_resp_ready   = 1'b0;

        req_valid_sel  = grant[1] ? lsu_req_valid  : (grant[0] & ifu_req_valid);
        resp_ready_sel = grant[1] ? lsu_resp_ready : (grant[0] & ifu_resp_ready);

        case (state)
            IDLE: begin
                // Grant is registered here so no m_req_valid reaches the slave
                // combinationally in the same cycle.
                if (ifu_req_valid && lsu_req_valid) begin
                    state_next = REQ;
                    if ((RR_MODE != 0) && last_lsu) begin
                        grant_next = 2'b01;
                    end else begin
                        grant_next = 2'b10;
                    end
                end else if (lsu_req_valid) begin
                    state_next = REQ;
                    grant_next = 2'b10;
                end else if (ifu_req_valid) begin
                    state_next = REQ;
                    grant_next = 2'b01;
                end
            end

            REQ: begin
                s_req_valid   = req_valid_sel;
                s_addr        = grant[1] ? lsu_addr  : ifu_addr;
                s_wen         = grant[1] ? lsu_wen   : ifu_wen;
                s_wdata       = grant[1] ? lsu_wdata : ifu_wdata;
                s_wmask       = grant[1] ? lsu_wmask : ifu_wmask;
                ifu_req_ready = grant[0] & s_req_ready;
                lsu_req_ready = grant[1] & s_req_ready;
                if (req_valid_sel && s_req_ready) begin
                    state_next = RESP;
                end
            end

            RESP: begin
                ifu_resp_valid = grant[0] & s_resp_valid;
                lsu_resp_valid = grant[1] & s_resp_valid;
                s_resp_ready   = resp_ready_sel;
                ifu_rdata      = s_rdata;
                lsu_rdata      = s_rdata;
                if (s_resp_valid && resp_ready_sel) begin
                    state_next    = IDLE;
                    grant_next    = 2'b00;
                    last_lsu_next = grant[1];
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter. Two instances
// share the stimulus: one round-robin, one fixed LSU priority, both with a
// short watchdog limit. Each table row is one clock cycle of inputs plus the
// outputs expected during that cycle.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, lsu_req_valid;
    logic          ifu_resp_ready, lsu_resp_ready;
    logic          s_req_ready, s_resp_valid;
    logic [AW-1:0] ifu_addr, lsu_addr;
    logic          ifu_wen, lsu_wen;
    logic [DW-1:0] ifu_wdata, lsu_wdata, s_rdata;
    logic [MW-1:0] ifu_wmask, lsu_wmask;

    // Round-robin instance outputs
    logic          r_ifu_req_ready, r_lsu_req_ready, r_ifu_resp_valid, r_lsu_resp_valid;
    logic [DW-1:0] r_ifu_rdata, r_lsu_rdata, r_s_wdata;
    logic          r_s_req_valid, r_s_wen, r_s_resp_ready, r_hang;
    logic [AW-1:0] r_s_addr;
    logic [MW-1:0] r_s_wmask;
    logic [1:0]    r_grant;

    // Fixed-priority instance outputs
    logic          f_ifu_req_ready, f_lsu_req_ready, f_ifu_resp_valid, f_lsu_resp_valid;
    logic [DW-1:0] f_ifu_rdata, f_lsu_rdata, f_s_wdata;
    logic          f_s_req_valid, f_s_wen, f_s_resp_ready, f_hang;
    logic [AW-1:0] f_s_addr;
    logic [MW-1:0] f_s_wmask;
    logic [1:0]    f_grant;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .HANG_CYCLES(4)) u_rr (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(r_ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_wen(ifu_wen), .ifu_wdata(ifu_wdata), .ifu_wmask(ifu_wmask),
        .ifu_resp_valid(r_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(r_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(r_lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(r_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(r_lsu_rdata),
        .s_req_valid(r_s_req_valid), .s_req_ready(s_req_ready), .s_addr(r_s_addr),
        .s_wen(r_s_wen), .s_wdata(r_s_wdata), .s_wmask(r_s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(r_s_resp_ready), .s_rdata(s_rdata),
        .grant(r_grant), .hang(r_hang)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .HANG_CYCLES(4)) u_fp (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(f_ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_wen(ifu_wen), .ifu_wdata(ifu_wdata), .ifu_wmask(ifu_wmask),
        .ifu_resp_valid(f_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(f_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(f_lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(f_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(f_lsu_rdata),
        .s_req_valid(f_s_req_valid), .s_req_ready(s_req_ready), .s_addr(f_s_addr),
        .s_wen(f_s_wen), .s_wdata(f_s_wdata), .s_wmask(f_s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(f_s_resp_ready), .s_rdata(s_rdata),
        .grant(f_grant), .hang(f_hang)
    );

    // Which instance the table rows are compared against
    logic use_fp;

    logic          m_ifu_req_ready, m_lsu_req_ready, m_ifu_resp_valid, m_lsu_resp_valid;
    logic [DW-1:0] m_ifu_rdata, m_lsu_rdata, m_s_wdata;
    logic          m_s_req_valid, m_s_wen, m_s_resp_ready, m_hang;
    logic [AW-1:0] m_s_addr;
    logic [MW-1:0] m_s_wmask;
    logic [1:0]    m_grant;

    assign m_ifu_req_ready  = use_fp ? f_ifu_req_ready  : r_ifu_req_ready;
    assign m_lsu_req_ready  = use_fp ? f_lsu_req_ready  : r_lsu_req_ready;
    assign m_ifu_resp_valid = use_fp ? f_ifu_resp_valid : r_ifu_resp_valid;
    assign m_lsu_resp_valid = use_fp ? f_lsu_resp_valid : r_lsu_resp_valid;
    assign m_ifu_rdata      = use_fp ? f_ifu_rdata      : r_ifu_rdata;
    assign m_lsu_rdata      = use_fp ? f_lsu_rdata      : r_lsu_rdata;
    assign m_s_req_valid    = use_fp ? f_s_req_valid    : r_s_req_valid;
    assign m_s_addr         = use_fp ? f_s_addr         : r_s_addr;
    assign m_s_wen          = use_fp ? f_s_wen          : r_s_wen;
    assign m_s_wdata        = use_fp ? f_s_wdata        : r_s_wdata;
    assign m_s_wmask        = use_fp ? f_s_wmask        : r_s_wmask;
    assign m_s_resp_ready   = use_fp ? f_s_resp_ready   : r_s_resp_ready;
    assign m_grant          = use_fp ? f_grant          : r_grant;
    assign m_hang           = use_fp ? f_hang           : r_hang;

    typedef struct {
        bit         iv, lv, srr, srv, imr, lmr;      // inputs for this cycle
        logic [1:0] grant;                           // expected outputs
        bit         sreqv, irr, lrr, irv, lrv, srespr;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t v(input bit iv, input bit lv, input bit srr, input bit srv,
                               input bit imr, input bit lmr, input logic [1:0] g,
                               input bit sreqv, input bit irr, input bit lrr,
                               input bit irv, input bit lrv, input bit srespr);
        vec_t t;
        t.iv = iv; t.lv = lv; t.srr = srr; t.srv = srv; t.imr = imr; t.lmr = lmr;
        t.grant = g; t.sreqv = sreqv; t.irr = irr; t.lrr = lrr;
        t.irv = irv; t.lrv = lrv; t.srespr = srespr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input bit iv, input bit lv, input bit srr, input bit srv,
                         input bit imr, input bit lmr);
        ifu_req_valid  = iv;
        lsu_req_valid  = lv;
        s_req_ready    = srr;
        s_resp_valid   = srv;
        ifu_resp_ready = imr;
        lsu_resp_ready = lmr;
    endtask

    // Checks every output of the selected instance against zero
    task automatic chk_all_zero(input string tag);
        chk({tag, ".grant"},     m_grant,          0);
        chk({tag, ".hang"},      m_hang,           0);
        chk({tag, ".s_req_v"},   m_s_req_valid,    0);
        chk({tag, ".s_addr"},    m_s_addr,         0);
        chk({tag, ".s_wen"},     m_s_wen,          0);
        chk({tag, ".s_wdata"},   m_s_wdata,        0);
        chk({tag, ".s_wmask"},   m_s_wmask,        0);
        chk({tag, ".s_resp_r"},  m_s_resp_ready,   0);
        chk({tag, ".ifu_req_r"}, m_ifu_req_ready,  0);
        chk({tag, ".lsu_req_r"}, m_lsu_req_ready,  0);
        chk({tag, ".ifu_rsp_v"}, m_ifu_resp_valid, 0);
        chk({tag, ".lsu_rsp_v"}, m_lsu_resp_valid, 0);
        chk({tag, ".ifu_rdata"}, m_ifu_rdata,      0);
        chk({tag, ".lsu_rdata"}, m_lsu_rdata,      0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One table row: drive in the low phase, compare just after
    task automatic apply(input string tag, input int idx, input vec_t t);
        string n;
        n = $sformatf("%s[%0d]", tag, idx);
        @(negedge clk);
        drive(t.iv, t.lv, t.srr, t.srv, t.imr, t.lmr);
        #1;
        chk({n, ".grant"},     m_grant,          t.grant);
        chk({n, ".s_req_v"},   m_s_req_valid,    t.sreqv);
        chk({n, ".ifu_req_r"}, m_ifu_req_ready,  t.irr);
        chk({n, ".lsu_req_r"}, m_lsu_req_ready,  t.lrr);
        chk({n, ".ifu_rsp_v"}, m_ifu_resp_valid, t.irv);
        chk({n, ".lsu_rsp_v"}, m_lsu_resp_valid, t.lrv);
        chk({n, ".s_resp_r"},  m_s_resp_ready,   t.srespr);
        if (t.sreqv) begin
            if (t.grant == 2'b10) begin
                chk({n, ".s_addr"},  m_s_addr,  32'h0000_1000);
                chk({n, ".s_wen"},   m_s_wen,   1);
                chk({n, ".s_wdata"}, m_s_wdata, 32'h1234_5678);
                chk({n, ".s_wmask"}, m_s_wmask, 4'hF);
            end else begin
                chk({n, ".s_addr"},  m_s_addr,  32'h8000_0000);
                chk({n, ".s_wen"},   m_s_wen,   0);
                chk({n, ".s_wdata"}, m_s_wdata, 32'hCAFE_0001);
                chk({n, ".s_wmask"}, m_s_wmask, 4'h2);
            end
        end
        if (t.irv || t.lrv) begin
            chk({n, ".ifu_rdata"}, m_ifu_rdata, 32'hDEAD_BEEF);
            chk({n, ".lsu_rdata"}, m_lsu_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic run_table(input string tag, input bit fp);
        use_fp = fp;
        do_reset();
        foreach (tbl[i]) apply(tag, i, tbl[i]);
        tbl.delete();
    endtask

    initial begin
        rst       = 1'b1;
        use_fp    = 1'b0;
        ifu_addr  = 32'h8000_0000; ifu_wen = 1'b0; ifu_wdata = 32'hCAFE_0001; ifu_wmask = 4'h2;
        lsu_addr  = 32'h0000_1000; lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
        s_rdata   = 32'hDEAD_BEEF;
        drive(0, 0, 0, 0, 0, 0);

        // Power-up reset: everything reads zero, then the FSM idles
        #3;
        chk_all_zero("por_rr");
        use_fp = 1'b1;
        chk_all_zero("por_fp");
        use_fp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d.grant", i), r_grant, 0);
            chk($sformatf("idle%0d.s_req_v", i), r_s_req_valid, 0);
        end

        // Single IFU read through a zero-wait slave
        tbl.push_back(v(1,0,1,1,1,0, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,1,0, 2'b01, 1,1,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,0, 2'b01, 0,0,0,1,0,1));
        tbl.push_back(v(0,0,1,1,1,0, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,0, 2'b00, 0,0,0,0,0,0));
        run_table("ifu_rd", 0);

        // Round-robin with both masters always requesting: LSU first
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 1,0,1,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 0,0,0,0,1,1));
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b01, 1,1,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b01, 0,0,0,1,0,1));
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 1,0,1,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 0,0,0,0,1,1));
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b01, 1,1,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,1, 2'b01, 0,0,0,1,0,1));
        tbl.push_back(v(0,0,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        run_table("rr", 0);

        // Fixed priority: LSU always wins until it stops requesting
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 1,0,1,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 0,0,0,0,1,1));
        tbl.push_back(v(1,1,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 1,0,1,0,0,0));
        tbl.push_back(v(1,1,1,1,1,1, 2'b10, 0,0,0,0,1,1));
        tbl.push_back(v(1,0,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,1,1, 2'b01, 1,1,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,1, 2'b01, 0,0,0,1,0,1));
        tbl.push_back(v(0,0,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        run_table("fp", 1);

        // LSU write stalled by the slave for 5 cycles while IFU waits
        tbl.push_back(v(1,1,0,0,0,1, 2'b00, 0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(1,1,0,0,0,1, 2'b10, 1,0,0,0,0,0));
        tbl.push_back(v(1,1,1,0,0,1, 2'b10, 1,0,1,0,0,0));
        tbl.push_back(v(1,0,1,1,0,1, 2'b10, 0,0,0,0,1,1));
        tbl.push_back(v(1,0,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,1,1, 2'b01, 1,1,0,0,0,0));
        tbl.push_back(v(0,0,1,1,1,1, 2'b01, 0,0,0,1,0,1));
        tbl.push_back(v(0,0,1,1,1,1, 2'b00, 0,0,0,0,0,0));
        run_table("stall", 0);

        // Watchdog: slave accepts the request but never responds
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        drive(1, 0, 1, 0, 1, 1);                 // IDLE cycle, request seen
        #1;
        chk("wd.c0.hang", r_hang, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 2) ifu_req_valid = 1'b0;    // request already accepted
            #1;
            chk($sformatf("wd.c%0d.hang", c), r_hang, (c >= 5) ? 1 : 0);
            chk($sformatf("wd.c%0d.grant", c), r_grant, 2'b01);
            chk($sformatf("wd.c%0d.ifu_rsp_v", c), r_ifu_resp_valid, 0);
        end

        // Reset in the middle of the hung RESP cycle clears everything at once
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("wd_rst");
        @(negedge clk);
        rst = 1'b0;
        s_resp_valid = 1'b1;                     // a late response must not leak out
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d.grant", c), r_grant, 0);
            chk($sformatf("post_rst%0d.hang", c), r_hang, 0);
            chk($sformatf("post_rst%0d.ifu_rsp_v", c), r_ifu_resp_valid, 0);
            chk($sformatf("post_rst%0d.lsu_rsp_v", c), r_lsu_resp_valid, 0);
            chk($sformatf("post_rst%0d.s_resp_r", c), r_s_resp_ready, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
